shift_arbiter: RTL and testbench

Shares one 16-bit shift unit between two requesters (port 0: execute-stage ALU path, port 1: secondary/address path) with round-robin arbitration and valid/ready handshakes. Accepted operations are computed combinationally and captured in a one-entry output buffer, giving one cycle of latency. The buffer drains downstream under back-pressure. Per-port saturating grant counters are exposed for performance debug.

---
 rtl/shift_arbiter.sv | 133 +++++++++++++
 tb/tb_shift_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one 16-bit shifter through round-robin
// arbitration. The result lands in a one-entry output buffer one cycle after
// the request is accepted. Per-port saturating grant counters are exposed for
// performance debug.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid[1:0]             per-port request valid
//   req_data0/1, req_amt0/1    operand and shift amount (0-15)
//   req_mode0/1                00 SLL, 01 SRA, 1x ROR
//   req_ready[1:0]             per-port accept (at most one bit set)
//   out_valid/out_ready        result buffer handshake
//   out_data, out_src          buffered result and the port that issued it
//   grant_cnt0/1               saturating accepted-request counters
module shift_arbiter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  input  logic [15:0]      req_data0,
  input  logic [15:0]      req_data1,
  input  logic [3:0]       req_amt0,
  input  logic [3:0]       req_amt1,
  input  logic [1:0]       req_mode0,
  input  logic [1:0]       req_mode1,
  output logic [1:0]       req_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_src,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  logic             out_valid_q, out_valid_d;
  logic [15:0]      out_data_q,  out_data_d;
  logic             out_src_q,   out_src_d;
  logic             ptr_q,       ptr_d;
  logic [CNT_W-1:0] cnt0_q,      cnt0_d;
  logic [CNT_W-1:0] cnt1_q,      cnt1_d;

  logic        space;
  logic        winner;
  logic        accept;
  logic [15:0] sel_data;
  logic [3:0]  sel_amt;
  logic [1:0]  sel_mode;
  logic [31:0] rot_dbl;
  logic [15:0] shift_res;

  // Arbitration and handshake
  always_comb begin
    // Ready is held low while reset is asserted, independent of the
    // buffer state, so no request is taken across a reset release.
    space  = (~out_valid_q | out_ready) & rst_n;
    winner = (&req_valid) ? ptr_q : req_valid[1];

    req_ready = '0;
    if (space) begin
      req_ready[winner] = req_valid[winner];
    end
    accept = |req_ready;
  end

  // Shared shifter, operands muxed by the arbitration winner
  always_comb begin
    sel_data = winner ? req_data1 : req_data0;
    sel_amt  = winner ? req_amt1  : req_amt0;
    sel_mode = winner ? req_mode1 : req_mode0;

    // Doubling the operand turns a rotate into a plain right shift.
    rot_dbl = {sel_data, sel_data} >> sel_amt;

    if (sel_mode[1]) begin
      shift_res = rot_dbl[15:0];
    end else if (sel_mode[0]) begin
      shift_res = $signed(sel_data) >>> sel_amt;
    end else begin
      shift_res = sel_data << sel_amt;
    end
  end

  // Buffer, pointer and counter next state
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = shift_res;
      out_src_d   = winner;
      ptr_d       = ~winner;
      if (!winner && cnt0_q != '1) begin
        cnt0_d = cnt0_q + 1'b1;
      end
      if (winner && cnt1_q != '1) begin
        cnt1_d = cnt1_q + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      ptr_q       <= 1'b0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_src    = out_src_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

  typedef struct packed {
    logic [15:0] d;
    logic        s;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data0, req_data1;
  logic [3:0]  req_amt0, req_amt1;
  logic [1:0]  req_mode0, req_mode1;
  logic [1:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_src;
  logic [7:0]  grant_cnt0, grant_cnt1;

  logic [1:0]  s_req_ready;
  logic        s_out_valid;
  logic [15:0] s_out_data;
  logic        s_out_src;
  logic [1:0]  s_cnt0, s_cnt1;

  exp_t sb[$];
  logic mptr;
  int   mc0, mc1;
  int   n_chk;
  int   n_fail;

  shift_arbiter #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req_data0(req_data0), .req_data1(req_data1),
    .req_amt0(req_amt0), .req_amt1(req_amt1),
    .req_mode0(req_mode0), .req_mode1(req_mode1),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  // Narrow-counter copy sharing all inputs, for saturation checks
  shift_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req_data0(req_data0), .req_data1(req_data1),
    .req_amt0(req_amt0), .req_amt1(req_amt1),
    .req_mode0(req_mode0), .req_mode1(req_mode1),
    .req_ready(s_req_ready), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_src(s_out_src),
    .grant_cnt0(s_cnt0), .grant_cnt1(s_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Monitor: compares the buffered result against the scoreboard head
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", int'(out_valid), int'(sb.size() != 0));
      if (out_valid && sb.size() != 0) begin
        chk("out_data", int'(out_data), int'(sb[0].d));
        chk("out_src", int'(out_src), int'(sb[0].s));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic step(
    input logic [1:0]  v,
    input logic [15:0] d0, input logic [3:0] a0, input logic [1:0] m0, input logic [15:0] e0,
    input logic [15:0] d1, input logic [3:0] a1, input logic [1:0] m1, input logic [15:0] e1,
    input logic        ordy
  );
    logic       space;
    logic       w;
    logic [1:0] er;
    req_valid = v;
    req_data0 = d0; req_amt0 = a0; req_mode0 = m0;
    req_data1 = d1; req_amt1 = a1; req_mode1 = m1;
    out_ready = ordy;
    @(negedge clk);
    #1;
    space = (sb.size() == 0) || ordy;
    w     = (v == 2'b11) ? mptr : v[1];
    er    = '0;
    if (space && v[w]) er[w] = 1'b1;
    chk("req_ready", int'(req_ready), int'(er));
    chk("req_ready_sat", int'(s_req_ready), int'(er));
    if (er != 2'b00) begin
      sb.push_back('{d: (w ? e1 : e0), s: w});
      mptr = ~w;
      if (w) mc1++;
      else   mc0++;
    end
    @(posedge clk);
    #1;
    chk("grant_cnt0", int'(grant_cnt0), sat(mc0, 255));
    chk("grant_cnt1", int'(grant_cnt1), sat(mc1, 255));
    chk("sat_cnt0", int'(s_cnt0), sat(mc0, 3));
    chk("sat_cnt1", int'(s_cnt1), sat(mc1, 3));
  endtask

  task automatic idle();
    step(2'b00, 16'h0, 4'h0, 2'b00, 16'h0, 16'h0, 4'h0, 2'b00, 16'h0, 1'b1);
  endtask

  // Asserts reset between edges with both ports requesting
  task automatic do_reset();
    req_valid = 2'b11;
    out_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_src", int'(out_src), 0);
    chk("rst_cnt0", int'(grant_cnt0), 0);
    chk("rst_cnt1", int'(grant_cnt1), 0);
    chk("rst_sat_cnt1", int'(s_cnt1), 0);
    sb.delete();
    mptr = 1'b0;
    mc0  = 0;
    mc1  = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold_ready", int'(req_ready), 0);
    req_valid = 2'b00;
    rst_n     = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    mptr = 1'b0; mc0 = 0; mc1 = 0;
    rst_n = 1'b0;
    req_valid = '0;
    req_data0 = '0; req_data1 = '0;
    req_amt0 = '0; req_amt1 = '0;
    req_mode0 = '0; req_mode1 = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset, then a tie resolves to port 0
    do_reset();
    step(2'b11, 16'h1111, 4'd0, 2'b00, 16'h1111, 16'h2222, 4'd0, 2'b00, 16'h2222, 1'b1);
    idle();

    // Per-mode results from port 0, back to back
    step(2'b01, 16'h8001, 4'd4,  2'b00, 16'h0010, 16'h0, 4'd0, 2'b00, 16'h0, 1'b1);
    step(2'b01, 16'h8001, 4'd4,  2'b01, 16'hF800, 16'h0, 4'd0, 2'b00, 16'h0, 1'b1);
    step(2'b01, 16'h8001, 4'd4,  2'b10, 16'h1800, 16'h0, 4'd0, 2'b00, 16'h0, 1'b1);
    step(2'b01, 16'h8001, 4'd4,  2'b11, 16'h1800, 16'h0, 4'd0, 2'b00, 16'h0, 1'b1);
    step(2'b01, 16'h1234, 4'd0,  2'b00, 16'h1234, 16'h0, 4'd0, 2'b00, 16'h0, 1'b1);
    step(2'b01, 16'h1234, 4'd0,  2'b01, 16'h1234, 16'h0, 4'd0, 2'b00, 16'h0, 1'b1);
    step(2'b01, 16'h1234, 4'd0,  2'b10, 16'h1234, 16'h0, 4'd0, 2'b00, 16'h0, 1'b1);
    step(2'b01, 16'h8000, 4'd15, 2'b01, 16'hFFFF, 16'h0, 4'd0, 2'b00, 16'h0, 1'b1);
    idle();

    // Contention: alternating grants, 4 each after 8 cycles
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(2'b11, 16'h00F0, 4'd4, 2'b00, 16'h0F00, 16'h00F0, 4'd4, 2'b10, 16'h000F, 1'b1);
    end
    chk("contention_cnt0", int'(grant_cnt0), 4);
    chk("contention_cnt1", int'(grant_cnt1), 4);
    idle();

    // Back-pressure: hold for 3 cycles, then drain and accept together
    step(2'b01, 16'hABCD, 4'd8, 2'b10, 16'hCDAB, 16'h0, 4'd0, 2'b00, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(2'b11, 16'h0001, 4'd1, 2'b00, 16'h0002, 16'h8000, 4'd1, 2'b01, 16'hC000, 1'b0);
    end
    step(2'b11, 16'h0001, 4'd1, 2'b00, 16'h0002, 16'h8000, 4'd1, 2'b01, 16'hC000, 1'b1);
    idle();
    idle();

    // Saturation on the 2-bit counter copy
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(2'b10, 16'h0, 4'd0, 2'b00, 16'h0, 16'h0003, 4'd1, 2'b00, 16'h0006, 1'b1);
    end
    chk("sat_final_cnt1", int'(s_cnt1), 3);
    chk("sat_final_cnt0", int'(s_cnt0), 0);
    chk("wide_final_cnt1", int'(grant_cnt1), 6);
    idle();

    // Async reset while the buffer is full
    step(2'b11, 16'h00FF, 4'd4, 2'b00, 16'h0FF0, 16'h0F00, 4'd4, 2'b10, 16'h00F0, 1'b0);
    chk("pre_reset_valid", int'(out_valid), int'(sb.size() != 0));
    do_reset();
    step(2'b11, 16'h00FF, 4'd4, 2'b00, 16'h0FF0, 16'h0F00, 4'd4, 2'b10, 16'h00F0, 1'b1);
    idle();
    idle();

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
